mul_result_collector: RTL and testbench
=======================================

# mul_result_collector

Downstream stage of the 32-bit shift-add multiplier controller. Holds for the multiplier's done indication, then captures the 64-bit product into a small first-word-fall-through queue. Returns a one-cycle acknowledge so the multiplier can go back to idle, and hands results to the consumer over a valid/ready handshake. Each result carries a wrapping sequence tag. The block also counts cycles in which the multiplier is stalled by a full queue.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits
- DEPTH, 4, queue entries; power of two, at least 2
- SEQ_W, 4, sequence tag width

Ports:
- Clock  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- iDone  in  1  multiplier in DONE state; level, held until acknowledged
- iProduct  in  2*WIDTH  product, stable while iDone=1
- oAck  out  1  one-cycle acknowledge to multiplier
- oValid  out  1  queue non-empty
- oProduct  out  2*WIDTH  head entry; 0 when empty
- oSeq  out  SEQ_W  head entry tag; 0 when empty
- iReady  in  1  consumer accepts head when oValid=1
- oFull  out  1  queue holds DEPTH entries
- oStallCycles  out  16  saturating count of cycles with iDone=1 and oFull=1 in S_WAIT

## Operation
- FSM states: S_WAIT and S_RELEASE.
- S_WAIT:
  - If iDone=1 and not full: push {iProduct, rSeq}, increment rSeq (wraps at 2^SEQ_W), register oAck=1, go to S_RELEASE.
  - If iDone=1 and full: stay, increment the stall counter.
  - Otherwise stay.
- S_RELEASE:
  - oAck=0.
  - Stay until iDone=0, then go to S_WAIT.
  - This state prevents a second capture of the same product while the multiplier leaves DONE.
- Pop: when oValid=1 and iReady=1, the read pointer advances.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full is evaluated on the current count. A push is refused when the queue is full, even if a pop occurs in the same cycle; the push happens one cycle later.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- The stall counter saturates at 16'hFFFF and never wraps.
- Reset (any cycle, including mid-handshake):
  - state=S_WAIT
  - pointers, count, rSeq, stall counter all 0
  - oAck=0
  - queue contents discarded

## Timing
- Reset values: oAck=0, oValid=0, oProduct=0, oSeq=0, oFull=0, oStallCycles=0.
- Capture happens at edge N, where iDone=1 in S_WAIT and the queue is not full.
  - oAck=1 during cycle N+1 only.
  - oValid=1 from cycle N+1 if the queue was empty (latency 1).
- Minimum spacing between captures: iDone must be seen low for at least one cycle in S_RELEASE.
- oAck is never asserted in two consecutive cycles.
- oValid, oProduct and oSeq are derived combinationally from the count and the head entry; they change only after edges.
- Head entry is stable while oValid=1 and iReady=0.
- If iDone=1 in the first cycle after Reset deasserts, the product is captured at that edge, tagged with sequence 0.

## Structure
- Shared package defines:
  - state encodings `STATE_WAIT 0 and `STATE_RELEASE 1
  - default WIDTH, DEPTH, SEQ_W
  - stall counter width (16)
- One sub-module, result_fifo:
  - parameterised storage, pointers and count
  - push/pop/full/empty
  - head data (FWFT)
- The top level holds the FSM, sequence counter, ack register and stall counter.

## Test plan
- Reset then idle: all outputs 0 for 10 cycles with iDone=0.
- Single result: iDone=1, iProduct=64'h0000_0001_0000_0002 held until oAck, then drops.
  - Required: oAck pulses once, one cycle after capture.
  - Required: oValid=1, oProduct=64'h0000_0001_0000_0002, oSeq=0.
  - Required: after iReady=1 for one cycle, oValid=0.
- Held iDone without deassert: iDone=1 for 5 cycles.
  - Required: exactly one push and one oAck; no second capture until iDone has been low.
- Full stall: iReady=0, four products captured, fifth iDone held 7 cycles.
  - Required: oFull=1, no oAck, oStallCycles=7.
  - Then iReady=1 for one cycle: the fifth product is captured on the following edge.
  - Required: pop order and oSeq are 0,1,2,3,4.
- Simultaneous push/pop with 2 entries: count stays 2, ordering preserved.
  - 17 captures: oSeq wraps 15 -> 0.
- Reset mid-operation: assert Reset with 3 entries queued and oAck pending.
  - Required: next cycle oValid=0 and oAck=0.
  - Required: the next capture has oSeq=0.

Source files
------------

// File: rtl/mul_result_collector_pkg.sv
// Shared types and defaults for the multiplier result collector.
// State encodings, default geometry, stall counter width.
package mul_result_collector_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SEQ_W = 4;
  localparam int STALL_W   = 16;

  localparam logic STATE_WAIT    = 1'b0;
  localparam logic STATE_RELEASE = 1'b1;

  typedef enum logic {
    S_WAIT    = STATE_WAIT,
    S_RELEASE = STATE_RELEASE
  } state_t;

endpackage

// File: rtl/mul_result_collector_if.sv
// Collector bus: multiplier done/ack side, consumer valid/ready side,
// plus full flag and stall count. slave = collector, master = environment.
interface mul_result_collector_if
  import mul_result_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEQ_W = DEF_SEQ_W
);

  logic               iDone;
  logic [2*WIDTH-1:0] iProduct;
  logic               oAck;
  logic               oValid;
  logic [2*WIDTH-1:0] oProduct;
  logic [SEQ_W-1:0]   oSeq;
  logic               iReady;
  logic               oFull;
  logic [STALL_W-1:0] oStallCycles;

  modport slave (
    input  iDone, iProduct, iReady,
    output oAck, oValid, oProduct, oSeq,
    output oFull, oStallCycles
  );

  modport master (
    output iDone, iProduct, iReady,
    input  oAck, oValid, oProduct, oSeq,
    input  oFull, oStallCycles
  );

endinterface

// File: rtl/mul_result_collector_fifo.sv
// result_fifo: first-word-fall-through queue of {product, tag}.
// Ports: push side (iPush, data), pop (iPop), oValid/oFull, head data.
module result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SEQ_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iPush,
  input  logic [2*WIDTH-1:0] iPushProduct,
  input  logic [SEQ_W-1:0]   iPushSeq,
  input  logic               iPop,
  output logic               oValid,
  output logic               oFull,
  output logic [2*WIDTH-1:0] oHeadProduct,
  output logic [SEQ_W-1:0]   oHeadSeq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2*WIDTH-1:0] memProduct [DEPTH];
  logic [SEQ_W-1:0]   memSeq     [DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [CNT_W-1:0]   count;
  logic               doPush;
  logic               doPop;

  assign oValid = (count != '0);
  assign oFull  = (count == CNT_W'(DEPTH));
  assign doPush = iPush && !oFull;
  assign doPop  = iPop && oValid;

  assign oHeadProduct = oValid ? memProduct[rdPtr] : '0;
  assign oHeadSeq     = oValid ? memSeq[rdPtr] : '0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)
        count <= count + 1'b1;
      else if (!doPush && doPop)
        count <= count - 1'b1;
    end
  end

  // Storage needs no reset; entries are only visible through count.
  always_ff @(posedge Clock) begin
    if (doPush) begin
      memProduct[wrPtr] <= iPushProduct;
      memSeq[wrPtr]     <= iPushSeq;
    end
  end

endmodule

// File: rtl/mul_result_collector.sv
// Captures multiplier products into a FWFT queue, acks the multiplier,
// tags results; ports: Clock, Reset, bus (collector side of the interface).
module mul_result_collector
  import mul_result_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEQ_W = DEF_SEQ_W
) (
  input logic Clock,
  input logic Reset,
  mul_result_collector_if.slave bus
);

  state_t             state;
  state_t             nextState;
  logic [SEQ_W-1:0]   rSeq;
  logic [SEQ_W-1:0]   nextSeq;
  logic               rAck;
  logic               nextAck;
  logic [STALL_W-1:0] rStall;
  logic [STALL_W-1:0] nextStall;
  logic               push;
  logic               pop;
  logic               full;
  logic               valid;
  logic [2*WIDTH-1:0] headProduct;
  logic [SEQ_W-1:0]   headSeq;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_WAIT;
      rSeq   <= '0;
      rAck   <= 1'b0;
      rStall <= '0;
    end else begin
      state  <= nextState;
      rSeq   <= nextSeq;
      rAck   <= nextAck;
      rStall <= nextStall;
    end
  end

  // S_RELEASE waits for iDone to fall so one DONE episode
  // yields exactly one capture.
  always_comb begin
    nextState = state;
    nextSeq   = rSeq;
    nextAck   = 1'b0;
    nextStall = rStall;
    push      = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (bus.iDone && !full) begin
          push      = 1'b1;
          nextSeq   = rSeq + 1'b1;
          nextAck   = 1'b1;
          nextState = S_RELEASE;
        end else if (bus.iDone && rStall != '1) begin
          nextStall = rStall + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!bus.iDone) nextState = S_WAIT;
      end
      default: nextState = S_WAIT;
    endcase
  end

  assign pop = valid && bus.iReady;

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) u_fifo (
    .Clock        (Clock),
    .Reset        (Reset),
    .iPush        (push),
    .iPushProduct (bus.iProduct),
    .iPushSeq     (rSeq),
    .iPop         (pop),
    .oValid       (valid),
    .oFull        (full),
    .oHeadProduct (headProduct),
    .oHeadSeq     (headSeq)
  );

  assign bus.oAck         = rAck;
  assign bus.oValid       = valid;
  assign bus.oFull        = full;
  assign bus.oProduct     = headProduct;
  assign bus.oSeq         = headSeq;
  assign bus.oStallCycles = rStall;

endmodule

// File: tb/tb_mul_result_collector.sv
// Self-checking bench for mul_result_collector: table of single results,
// scoreboard queue for ordering, hand sequences for stall/wrap/reset.
module tb_mul_result_collector;

  logic Clock;
  logic Reset;

  mul_result_collector_if #(.WIDTH(32), .SEQ_W(4)) bus ();

  mul_result_collector #(
    .WIDTH (32),
    .DEPTH (4),
    .SEQ_W (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [63:0] p;
    logic [3:0]  s;
  } ent_t;

  typedef struct {
    logic [63:0] product;
    logic [3:0]  seq;
  } vec_t;

  ent_t       sb[$];
  logic [3:0] expSeq;
  int         total;
  int         bad;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    Reset = 1'b1;
    bus.iDone = 1'b0;
    bus.iReady = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    sb.delete();
    expSeq = '0;
  endtask

  // Hold iDone until ack; latency must be one edge when not full.
  task automatic capture(input logic [63:0] p, input string name);
    int  n;
    bit  got;
    bus.iDone = 1'b1;
    bus.iProduct = p;
    sb.push_back({p, expSeq});
    expSeq++;
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (bus.oAck) got = 1;
    end
    chk({name, " ack latency"}, 128'(n), 128'(1));
    bus.iDone = 1'b0;
    tick();
    chk({name, " ack one cycle"}, 128'(bus.oAck), 128'(0));
  endtask

  task automatic popOne(input string name);
    ent_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got pop want empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      chk({name, " valid"}, 128'(bus.oValid), 128'(1));
      chk({name, " product"}, 128'(bus.oProduct), 128'(e.p));
      chk({name, " seq"}, 128'(bus.oSeq), 128'(e.s));
    end
    bus.iReady = 1'b1;
    tick();
    bus.iReady = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    int   acks;
    ent_t e;
    total = 0;
    bad = 0;
    bus.iProduct = '0;

    vecs[0] = '{64'h0000_0001_0000_0002, 4'd0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd1};
    vecs[2] = '{64'h0000_0000_0000_0000, 4'd2};
    vecs[3] = '{64'h1234_5678_9ABC_DEF0, 4'd3};

    doReset();
    for (int i = 0; i < 10; i++) begin
      chk("idle outputs",
          128'({bus.oAck, bus.oValid, bus.oFull,
                bus.oProduct, bus.oSeq, bus.oStallCycles}),
          128'(0));
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      capture(vecs[i].product, "single");
      chk("single tag", 128'(sb[0].s), 128'(vecs[i].seq));
      popOne("single head");
      chk("single empty", 128'(bus.oValid), 128'(0));
      chk("single noack", 128'(bus.oAck), 128'(0));
    end

    bus.iDone = 1'b1;
    bus.iProduct = 64'hCAFE_0000_0000_BEEF;
    sb.push_back({bus.iProduct, expSeq});
    expSeq++;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.oAck) acks++;
    end
    bus.iDone = 1'b0;
    tick();
    chk("held ack count", 128'(acks), 128'(1));
    popOne("held head");
    chk("held single push", 128'(bus.oValid), 128'(0));

    doReset();
    for (int i = 0; i < 4; i++)
      capture({32'(i), 32'h0F0F_0000 + 32'(i)}, "fill");
    chk("fill full", 128'(bus.oFull), 128'(1));
    bus.iDone = 1'b1;
    bus.iProduct = 64'h5555_AAAA_5555_AAAA;
    sb.push_back({bus.iProduct, expSeq});
    expSeq++;
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.oAck) acks++;
    end
    chk("stall no ack", 128'(acks), 128'(0));
    chk("stall full", 128'(bus.oFull), 128'(1));
    chk("stall count", 128'(bus.oStallCycles), 128'(7));
    popOne("stall pop");
    chk("stall pop edge", 128'(bus.oStallCycles), 128'(8));
    chk("stall pop noack", 128'(bus.oAck), 128'(0));
    tick();
    chk("stall late ack", 128'(bus.oAck), 128'(1));
    bus.iDone = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) popOne("stall order");
    chk("stall drained", 128'(bus.oValid), 128'(0));
    chk("stall not full", 128'(bus.oFull), 128'(0));

    doReset();
    capture(64'h1, "pp prime");
    capture(64'h2, "pp prime");
    for (int i = 0; i < 17; i++) begin
      e = sb.pop_front();
      chk("pp head", 128'(bus.oProduct), 128'(e.p));
      chk("pp seq", 128'(bus.oSeq), 128'(e.s));
      bus.iReady = 1'b1;
      bus.iDone = 1'b1;
      bus.iProduct = {32'(i), 32'hA5A5_0000 + 32'(i)};
      sb.push_back({bus.iProduct, expSeq});
      expSeq++;
      tick();
      chk("pp ack", 128'(bus.oAck), 128'(1));
      chk("pp count", 128'({bus.oValid, bus.oFull}), 128'(2'b10));
      bus.iReady = 1'b0;
      bus.iDone = 1'b0;
      tick();
    end
    popOne("pp drain");
    popOne("pp drain");
    chk("pp empty", 128'(bus.oValid), 128'(0));

    doReset();
    capture(64'hAA, "mid");
    capture(64'hBB, "mid");
    bus.iDone = 1'b1;
    bus.iProduct = 64'hCC;
    tick();
    chk("mid ack pending", 128'(bus.oAck), 128'(1));
    Reset = 1'b1;
    bus.iDone = 1'b0;
    tick();
    chk("mid reset valid", 128'(bus.oValid), 128'(0));
    chk("mid reset ack", 128'(bus.oAck), 128'(0));
    Reset = 1'b0;
    sb.delete();
    expSeq = '0;
    capture(64'hDD, "post reset");
    popOne("post reset");
    chk("post reset empty", 128'(bus.oValid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
